multicycle_controller: RTL and testbench

Main sequencing FSM for the multi-cycle RV32 core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the format select of the immediate generator, ALU control, PC/IR/register-file write strobes and the instruction- and data-memory request handshakes.
- Supports opcodes 3 (load), 19 (I-ALU), 35 (store), 51 (R-type) and 99 (branch); anything else traps.

---
 rtl/rv_ctrl_pkg.sv | 46 ++++
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control unit: opcode
// constants, FSM state encoding and the immediate/ALU control encodings.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IALU   = 7'd19;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_BRANCH = 7'd99;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [1:0] IMM_NONE = 2'd0;
    localparam logic [1:0] IMM_I    = 2'd1;
    localparam logic [1:0] IMM_S    = 2'd2;
    localparam logic [1:0] IMM_SB   = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Immediate format implied by an opcode; R-type and unknown opcodes use none.
    function automatic logic [1:0] imm_fmt(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IALU: imm_fmt = IMM_I;
            OP_STORE:         imm_fmt = IMM_S;
            OP_BRANCH:        imm_fmt = IMM_SB;
            default:          imm_fmt = IMM_NONE;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IALU, OP_STORE, OP_RTYPE, OP_BRANCH: is_legal = 1'b1;
            default:                                         is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32 core (FETCH, DECODE, EXEC,
// MEM, WB, TRAP). Optional retired-instruction counter enabled by defining
// MC_PERF_CNT_EN; without it instret reads 0 and no counter flops exist.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [1:0]  imm_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam bit         TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        illegal_q, illegal_d;
    logic        run_q;
    logic        retire;

    // Run flag: keeps every request low while reset is held, so imem_req
    // first rises on the clock edge after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // State, latched opcode, wait counter and sticky illegal flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic and combinational control outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tmo_d     = tmo_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        imm_sel   = IMM_NONE;
        alu_src   = 1'b0;
        alu_op    = ALU_ADD;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (TMO_EN && tmo_q == TMO_LAST) begin
                        state_d = ST_TRAP;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            ST_DECODE: begin
                op_d    = opcode;
                imm_sel = imm_fmt(opcode);
                state_d = is_legal(opcode) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                imm_sel = imm_fmt(op_q);
                case (op_q)
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        state_d = ST_MEM;
                    end
                    OP_IALU: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_FUNCT;
                        state_d = ST_WB;
                    end
                    OP_RTYPE: begin
                        alu_op  = ALU_FUNCT;
                        state_d = ST_WB;
                    end
                    OP_BRANCH: begin
                        alu_op   = ALU_CMP;
                        pc_write = branch_taken;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (dmem_ready) begin
                    retire  = (op_q == OP_STORE);
                    state_d = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    state_d = ST_TRAP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = (op_q == OP_LOAD);
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase

        if (state_d != state_q) tmo_d = '0;
        illegal_d = illegal_q | (state_d == ST_TRAP);
    end

    assign illegal = illegal_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] instret_q, instret_d;

    assign instret_d = instret_q + {31'd0, retire};

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) instret_q <= '0;
        else        instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT=4). Control outputs
// are packed as {imem_req, ir_write, pc_write, pc_src, imm_sel, alu_src,
// alu_op, dmem_req, dmem_we, reg_write, wb_sel, illegal}.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = '0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_write, pc_write, pc_src, alu_src;
    logic        dmem_req, dmem_we, reg_write, wb_sel, illegal;
    logic [1:0]  imm_sel, alu_op;
    logic [31:0] instret;

    int          checks = 0;
    int          failures = 0;
    logic [13:0] e;
    logic [31:0] exp_instret = 0;
    logic [31:0] e32;

    wire [13:0] ctl = {imem_req, ir_write, pc_write, pc_src, imm_sel, alu_src,
                       alu_op, dmem_req, dmem_we, reg_write, wb_sel, illegal};

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .imm_sel(imm_sel), .alu_src(alu_src), .alu_op(alu_op),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .wb_sel(wb_sel), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        e = 14'b0000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", ctl, e); end
        checks++;
        if (instret !== 32'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL release_before_edge got=%b exp=%b", ctl, e); end
        tick();
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL first_fetch got=%b exp=%b", ctl, e); end
    endtask

    task automatic test_rtype();
        opcode = 7'd51; imem_ready = 1'b1; #1;
        e = 14'b1110_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL rt_fetch got=%b exp=%b", ctl, e); end
        tick(); imem_ready = 1'b0; #1;
        e = 14'b0000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL rt_decode got=%b exp=%b", ctl, e); end
        tick(); #1;
        e = 14'b0000_00_0_10_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL rt_exec got=%b exp=%b", ctl, e); end
        tick(); #1;
        e = 14'b0000_00_0_00_00_10_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL rt_wb got=%b exp=%b", ctl, e); end
        tick(); #1;
        exp_instret = exp_instret + 1;
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL rt_refetch got=%b exp=%b", ctl, e); end
    endtask

    task automatic test_load_wait();
        opcode = 7'd3; imem_ready = 1'b1; #1;
        tick(); imem_ready = 1'b0; #1;
        e = 14'b0000_01_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ld_decode got=%b exp=%b", ctl, e); end
        tick(); #1;
        e = 14'b0000_01_1_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ld_exec got=%b exp=%b", ctl, e); end
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_ready = (i == 3); #1;
            e = 14'b0000_00_0_00_10_00_0; checks++;
            if (ctl !== e) begin failures++; $display("FAIL ld_mem%0d got=%b exp=%b", i, ctl, e); end
        end
        tick(); dmem_ready = 1'b0; #1;
        e = 14'b0000_00_0_00_00_11_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ld_wb got=%b exp=%b", ctl, e); end
        tick(); #1;
        exp_instret = exp_instret + 1;
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ld_refetch got=%b exp=%b", ctl, e); end
    endtask

    task automatic test_store();
        opcode = 7'd35; imem_ready = 1'b1; #1;
        tick(); imem_ready = 1'b0; #1;
        e = 14'b0000_10_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL st_decode got=%b exp=%b", ctl, e); end
        tick(); #1;
        e = 14'b0000_10_1_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL st_exec got=%b exp=%b", ctl, e); end
        tick(); dmem_ready = 1'b1; #1;
        e = 14'b0000_00_0_00_11_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL st_mem got=%b exp=%b", ctl, e); end
        tick(); dmem_ready = 1'b0; #1;
        exp_instret = exp_instret + 1;
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL st_refetch got=%b exp=%b", ctl, e); end
    endtask

    task automatic test_branch(input logic taken);
        opcode = 7'd99; imem_ready = 1'b1; #1;
        tick(); imem_ready = 1'b0; #1;
        e = 14'b0000_11_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL br%0d_decode got=%b exp=%b", taken, ctl, e); end
        tick(); branch_taken = taken; #1;
        e = taken ? 14'b0011_11_0_01_00_00_0 : 14'b0001_11_0_01_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL br%0d_exec got=%b exp=%b", taken, ctl, e); end
        tick(); branch_taken = 1'b0; #1;
        exp_instret = exp_instret + 1;
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL br%0d_refetch got=%b exp=%b", taken, ctl, e); end
    endtask

    task automatic test_fetch_wait_ialu();
        opcode = 7'd19;
        for (int i = 0; i < 2; i++) begin
            #1;
            e = 14'b1000_00_0_00_00_00_0; checks++;
            if (ctl !== e) begin failures++; $display("FAIL fw_wait%0d got=%b exp=%b", i, ctl, e); end
            tick();
        end
        imem_ready = 1'b1; #1;
        e = 14'b1110_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL fw_accept got=%b exp=%b", ctl, e); end
        tick(); imem_ready = 1'b0; dmem_ready = 1'b1; #1;
        tick(); #1;
        e = 14'b0000_01_1_10_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ia_exec got=%b exp=%b", ctl, e); end
        tick(); #1;
        e = 14'b0000_00_0_00_00_10_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ia_wb_stray_ready got=%b exp=%b", ctl, e); end
        tick(); dmem_ready = 1'b0; #1;
        exp_instret = exp_instret + 1;
        e32 = exp_instret;
`ifndef MC_PERF_CNT_EN
        e32 = 32'd0;
`endif
        checks++;
        if (instret !== e32) begin failures++; $display("FAIL instret_count got=%0d exp=%0d", instret, e32); end
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf_wrap();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        checks++;
        if (instret !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", instret); end
        opcode = 7'd51; imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        tick(); tick(); tick(); #1;
        checks++;
        if (instret !== 32'd0) begin failures++; $display("FAIL wrap_zero got=%h exp=00000000", instret); end
    endtask
`endif

    task automatic test_illegal();
        opcode = 7'h7F; imem_ready = 1'b1; #1;
        tick(); imem_ready = 1'b0; #1;
        e = 14'b0000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ill_decode got=%b exp=%b", ctl, e); end
        imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            e = 14'b0000_00_0_00_00_00_1; checks++;
            if (ctl !== e) begin failures++; $display("FAIL ill_trap%0d got=%b exp=%b", i, ctl, e); end
        end
        reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; #1;
        e = 14'b0000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ill_reset_clear got=%b exp=%b", ctl, e); end
        exp_instret = 0;
        checks++;
        if (instret !== 32'd0) begin failures++; $display("FAIL ill_reset_instret got=%0d exp=0", instret); end
        tick(); reset = 1'b1; #1;
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL ill_release got=%b exp=%b", ctl, e); end
        tick();
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL ill_refetch got=%b exp=%b", ctl, e); end
    endtask

    task automatic test_timeout_and_async_reset();
        opcode = 7'd3; imem_ready = 1'b1; #1;
        tick(); imem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            e = 14'b0000_00_0_00_10_00_0; checks++;
            if (ctl !== e) begin failures++; $display("FAIL to_mem%0d got=%b exp=%b", i, ctl, e); end
        end
        tick(); #1;
        e = 14'b0000_00_0_00_00_00_1; checks++;
        if (ctl !== e) begin failures++; $display("FAIL to_trap got=%b exp=%b", ctl, e); end
        reset = 1'b0; #1;
        tick(); reset = 1'b1;
        tick(); #1;
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL to_refetch got=%b exp=%b", ctl, e); end
        reset = 1'b0; #1;
        e = 14'b0000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL async_req_drop got=%b exp=%b", ctl, e); end
        imem_ready = 1'b1;
        tick();
        checks++;
        if (ctl !== e) begin failures++; $display("FAIL late_ready_ignored got=%b exp=%b", ctl, e); end
        imem_ready = 1'b0; reset = 1'b1;
        tick();
        e = 14'b1000_00_0_00_00_00_0; checks++;
        if (ctl !== e) begin failures++; $display("FAIL post_reset_fetch got=%b exp=%b", ctl, e); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_fetch_wait_ialu();
`ifdef MC_PERF_CNT_EN
        test_perf_wrap();
`endif
        test_illegal();
        test_timeout_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
